// File: rtl/sample_requester.sv
`default_nettype none
// ============================================================================
// Module  : sample_requester
// Purpose : Consumer end of the sine_reader request/response interface.
//           Raises a one-cycle generate_next at a fixed sample interval,
//           captures the returned sample on sample_ready, and buffers it in
//           a small FIFO. The FIFO drains downstream through a valid/ready
//           handshake. Lost requests, response timeouts and FIFO overflow
//           are reported on sticky flags and a saturating drop counter.
// Ports   : clk           system clock
//           reset         synchronous, active-low reset
//           enable        allow new requests (period counter runs)
//           clear_err     clears sticky flags and drop_count
//           generate_next one-cycle request pulse to sine_reader
//           sample_ready  one-cycle response strobe from sine_reader
//           sample        signed 16-bit sample, valid with sample_ready
//           out_valid     FIFO non-empty
//           out_ready     downstream accepts the head entry
//           out_sample    FIFO head (0 while empty)
//           overflow      sticky: sample dropped because the FIFO was full
//           timeout_err   sticky: request got no response within TIMEOUT
//           overrun       sticky: tick arrived while a request was pending
//           drop_count    saturating count of the three events above
// Revision: 1.0 - initial release
// ============================================================================
module sample_requester #(
  parameter int SAMPLE_PERIOD = 16,
  parameter int TIMEOUT       = 8,
  parameter int FIFO_DEPTH    = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  input  logic        clear_err,
  output logic        generate_next,
  input  logic        sample_ready,
  input  logic [15:0] sample,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] out_sample,
  output logic        overflow,
  output logic        timeout_err,
  output logic        overrun,
  output logic [7:0]  drop_count
);

  localparam int CW = $clog2(SAMPLE_PERIOD);
  localparam int WW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int PW = AW + 1;

  localparam logic [CW-1:0] PERIOD_LAST = CW'(SAMPLE_PERIOD - 1);
  localparam logic [WW-1:0] WAIT_LAST   = WW'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2
  } state_t;

  // --------------------------------------------------------------------------
  // Period counter
  // --------------------------------------------------------------------------
  logic [CW-1:0] period_cnt;
  logic          tick;

  assign tick = enable && (period_cnt == PERIOD_LAST);

  always_ff @(posedge clk) begin
    if (!reset) begin
      period_cnt <= '0;
    end else if (!enable || tick) begin
      period_cnt <= '0;
    end else begin
      period_cnt <= period_cnt + CW'(1);
    end
  end

  // --------------------------------------------------------------------------
  // Request FSM
  // --------------------------------------------------------------------------
  state_t        state, state_nxt;
  logic [WW-1:0] wait_cnt, wait_cnt_nxt;
  logic          capture;
  logic          timeout_evt;
  logic          overrun_evt;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state    <= S_IDLE;
      wait_cnt <= '0;
    end else begin
      state    <= state_nxt;
      wait_cnt <= wait_cnt_nxt;
    end
  end

  always_comb begin
    state_nxt     = state;
    wait_cnt_nxt  = wait_cnt;
    generate_next = 1'b0;
    capture       = 1'b0;
    timeout_evt   = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (tick) state_nxt = S_REQ;
      end
      S_REQ: begin
        generate_next = 1'b1;
        wait_cnt_nxt  = '0;
        state_nxt     = S_WAIT;
      end
      S_WAIT: begin
        // A response in the last allowed cycle still wins over the timeout.
        if (sample_ready) begin
          capture   = 1'b1;
          state_nxt = S_IDLE;
        end else if (wait_cnt == WAIT_LAST) begin
          timeout_evt = 1'b1;
          state_nxt   = S_IDLE;
        end else begin
          wait_cnt_nxt = wait_cnt + WW'(1);
        end
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  // A tick that lands on an outstanding request is skipped, not queued.
  assign overrun_evt = tick && (state != S_IDLE);

  // --------------------------------------------------------------------------
  // Output FIFO (pointers carry an extra wrap bit for full/empty detection)
  // --------------------------------------------------------------------------
  logic [15:0]   mem [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic          fifo_empty, fifo_full;
  logic          push, pop;
  logic          overflow_evt;

  assign fifo_empty = (wr_ptr == rd_ptr);
  assign fifo_full  = (wr_ptr[AW] != rd_ptr[AW]) &&
                      (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

  assign out_valid    = !fifo_empty;
  assign pop          = out_valid && out_ready;
  // When full, a simultaneous pop frees the slot being written this edge.
  assign push         = capture && (!fifo_full || pop);
  assign overflow_evt = capture && fifo_full && !pop;

  assign out_sample = out_valid ? mem[rd_ptr[AW-1:0]] : 16'h0000;

  always_ff @(posedge clk) begin
    if (reset && push) begin
      mem[wr_ptr[AW-1:0]] <= sample;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
    end
  end

  // --------------------------------------------------------------------------
  // Sticky flags and drop counter
  // --------------------------------------------------------------------------
  logic [1:0] n_evt;
  logic [8:0] drop_sum;
  logic [7:0] drop_sat;

  assign n_evt    = {1'b0, overflow_evt} + {1'b0, timeout_evt} + {1'b0, overrun_evt};
  assign drop_sum = {1'b0, drop_count} + {7'd0, n_evt};
  assign drop_sat = drop_sum[8] ? 8'hFF : drop_sum[7:0];

  always_ff @(posedge clk) begin
    if (!reset) begin
      overflow    <= 1'b0;
      timeout_err <= 1'b0;
      overrun     <= 1'b0;
      drop_count  <= 8'd0;
    end else if (clear_err) begin
      // Events in the clearing cycle survive the clear.
      overflow    <= overflow_evt;
      timeout_err <= timeout_evt;
      overrun     <= overrun_evt;
      drop_count  <= {6'd0, n_evt};
    end else begin
      overflow    <= overflow    | overflow_evt;
      timeout_err <= timeout_err | timeout_evt;
      overrun     <= overrun     | overrun_evt;
      drop_count  <= drop_sat;
    end
  end

endmodule
`default_nettype wire
